// File: rtl/hb_read_watchdog.sv
// Per-channel HyperBus read watchdog: arms on read start, reloads on RWDS activity,
// pulses timeout_o when a read stalls. Event counters exist only with HB_WDOG_EVT_CNT_EN.
module hb_read_watchdog #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 8,
    parameter int EVT_W  = 4
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic [CNT_W-1:0]        timeout_cycles_i,
    input  logic [NUM_CH-1:0]       rd_start_i,
    input  logic [NUM_CH-1:0]       rd_done_i,
    input  logic [NUM_CH-1:0]       rwds_edge_i,
    input  logic [NUM_CH-1:0]       status_clr_i,
    output logic [NUM_CH-1:0]       busy_o,
    output logic [NUM_CH-1:0]       timeout_o,
    output logic [NUM_CH-1:0]       status_o,
    output logic [NUM_CH*EVT_W-1:0] evt_cnt_o
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ARMED = 1'b1;

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        logic [0:0]       state_r;
        logic [CNT_W-1:0] cnt_r;
        logic             timeout_r;
        logic             status_r;
        logic             expire_s;

        // Expiry only when armed, counter drained and no start/done/edge this cycle.
        assign expire_s = (state_r == ARMED) && !rd_start_i[n] && !rd_done_i[n]
                          && !rwds_edge_i[n] && (cnt_r == {CNT_W{1'b0}});

        // Channel FSM, down-counter, timeout pulse and sticky status.
        always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
            if (wb_rst_i) begin
                state_r   <= IDLE;
                cnt_r     <= {CNT_W{1'b0}};
                timeout_r <= 1'b0;
                status_r  <= 1'b0;
            end else begin
                timeout_r <= expire_s;
                case (state_r)
                    IDLE: begin
                        if (rd_start_i[n]) begin
                            cnt_r   <= timeout_cycles_i;
                            state_r <= ARMED;
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                    ARMED: begin
                        if (rd_start_i[n]) begin
                            cnt_r <= timeout_cycles_i;
                        end else if (rd_done_i[n]) begin
                            state_r <= IDLE;
                        end else if (rwds_edge_i[n]) begin
                            cnt_r <= timeout_cycles_i;
                        end else if (cnt_r != {CNT_W{1'b0}}) begin
                            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                    end
                endcase
                // A timeout in the same cycle as a clear leaves the flag set.
                if (expire_s) begin
                    status_r <= 1'b1;
                end else if (status_clr_i[n]) begin
                    status_r <= 1'b0;
                end else begin
                    status_r <= status_r;
                end
            end
        end

        assign busy_o[n]    = (state_r == ARMED);
        assign timeout_o[n] = timeout_r;
        assign status_o[n]  = status_r;

`ifdef HB_WDOG_EVT_CNT_EN
        logic [EVT_W-1:0] evt_r;

        // Saturating timeout event counter; untouched by status clear.
        always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
            if (wb_rst_i) begin
                evt_r <= {EVT_W{1'b0}};
            end else if (expire_s && (evt_r != {EVT_W{1'b1}})) begin
                evt_r <= evt_r + {{(EVT_W-1){1'b0}}, 1'b1};
            end else begin
                evt_r <= evt_r;
            end
        end

        assign evt_cnt_o[n*EVT_W +: EVT_W] = evt_r;
`else
        assign evt_cnt_o[n*EVT_W +: EVT_W] = {EVT_W{1'b0}};
`endif
    end

endmodule
